// File: rtl/dsc_pair_sng.sv
// Converts a sorted (a, b) operand pair into two 2^SNG_WIDTH-beat unary bitstreams.
// Latency: the first beat (cnt = 0) is valid the cycle after the pair is accepted; one beat per accepted cycle.
// Backpressure: out_ready low freezes cnt and all outputs; a new pair is accepted only in IDLE or on the final accepted beat.
module dsc_pair_sng #(
  parameter int SNG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SNG_WIDTH-1:0] a_in,
  input  logic [SNG_WIDTH-1:0] b_in,
  input  logic                 mode_in,
  output logic                 bs_valid,
  input  logic                 out_ready,
  output logic                 a_bs,
  output logic                 b_bs,
  output logic                 bs_last
);

  localparam logic [SNG_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [SNG_WIDTH-1:0] a_reg;
  logic [SNG_WIDTH-1:0] b_reg;
  logic                 mode_reg;
  logic [SNG_WIDTH-1:0] cnt;
  logic [SNG_WIDTH-1:0] cmp_b;
  logic                 load;
  logic                 beat;

  // Mirror the counter bits so B's ones spread evenly over the stream.
  function automatic logic [SNG_WIDTH-1:0] bitrev(input logic [SNG_WIDTH-1:0] v);
    logic [SNG_WIDTH-1:0] r;
    for (int i = 0; i < SNG_WIDTH; i++) begin
      r[i] = v[SNG_WIDTH-1-i];
    end
    return r;
  endfunction

  assign cmp_b = mode_reg ? bitrev(cnt) : cnt;

  // Decode outputs and handshakes from registered state; pick the next state.
  always_comb begin
    state_nxt = state;
    bs_valid  = 1'b0;
    a_bs      = 1'b0;
    b_bs      = 1'b0;
    bs_last   = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
      end
      STREAM: begin
        bs_valid = 1'b1;
        a_bs     = (a_reg > cnt);
        b_bs     = (b_reg > cmp_b);
        bs_last  = (cnt == CNT_MAX);
        // Accepting on the last beat gives back-to-back streams with no bubble.
        in_ready = rst_n && bs_last && out_ready;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    load = in_valid && in_ready;
    beat = bs_valid && out_ready;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (beat && bs_last) begin
          state_nxt = load ? STREAM : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset discards any stream in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture on accept; counter advances once per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      mode_reg <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      a_reg    <= a_in;
      b_reg    <= b_in;
      mode_reg <= mode_in;
      cnt      <= '0;
    end else if (beat && !bs_last) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dsc_pair_sng.sv
module tb_dsc_pair_sng;

  localparam int W = 6;
  localparam int N = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         mode_in;
  logic         bs_valid;
  logic         out_ready;
  logic         a_bs;
  logic         b_bs;
  logic         bs_last;

  dsc_pair_sng #(.SNG_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .mode_in   (mode_in),
    .bs_valid  (bs_valid),
    .out_ready (out_ready),
    .a_bs      (a_bs),
    .b_bs      (b_bs),
    .bs_last   (bs_last)
  );

  typedef struct {
    int a;
    int b;
    int last;
  } beat_t;

  typedef struct {
    int a;
    int b;
    int ab;
  } totals_t;

  beat_t   exp_q[$];
  totals_t str_q[$];
  int      checks   = 0;
  int      failures = 0;
  bit      stall_en = 0;
  int      ca, cb, cab;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rev_int(input int v);
    int r = 0;
    for (int k = 0; k < W; k++) begin
      r = r + (((v >> k) & 1) << (W - 1 - k));
    end
    return r;
  endfunction

  // Reference: A has ones at the first a positions; B has ones at the first b
  // positions (correlated) or at the positions visited by the first b steps of
  // the bit-reversed counting order (uncorrelated).
  function automatic void push_pair(input int a, input int b, input int m);
    int      pa[N];
    int      pb[N];
    totals_t t;
    beat_t   e;
    for (int i = 0; i < N; i++) begin
      pa[i] = (i < a) ? 1 : 0;
      pb[i] = 0;
    end
    for (int v = 0; v < b; v++) begin
      pb[(m != 0) ? rev_int(v) : v] = 1;
    end
    t.a = a; t.b = b; t.ab = 0;
    for (int i = 0; i < N; i++) begin
      e.a = pa[i]; e.b = pb[i]; e.last = (i == N - 1) ? 1 : 0;
      exp_q.push_back(e);
      t.ab = t.ab + (pa[i] & pb[i]);
    end
    str_q.push_back(t);
  endfunction

  // Random backpressure when enabled, otherwise always ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: handshake expectations every cycle, beat-by-beat and per-stream compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      ca = 0; cb = 0; cab = 0;
    end else begin
      chk("bs_valid", int'(bs_valid), (exp_q.size() > 0) ? 1 : 0);
      chk("in_ready", int'(in_ready),
          (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready)) ? 1 : 0);
      if (bs_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat: got beat a=%0d b=%0d last=%0d expected none", a_bs, b_bs, bs_last);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("a_bs", int'(a_bs), e.a);
          chk("b_bs", int'(b_bs), e.b);
          chk("bs_last", int'(bs_last), e.last);
          ca  = ca + int'(a_bs);
          cb  = cb + int'(b_bs);
          cab = cab + int'(a_bs & b_bs);
          if (e.last != 0 && str_q.size() > 0) begin
            totals_t t;
            t = str_q.pop_front();
            chk("ones_a", ca, t.a);
            chk("ones_b", cb, t.b);
            chk("ones_ab", cab, t.ab);
            ca = 0; cb = 0; cab = 0;
          end
        end
      end
    end
  end

  // Present a pair and hold it until accepted; optionally scramble the data while waiting.
  task automatic send(input int a, input int b, input int m, input bit scramble);
    int budget = 0;
    in_valid = 1'b1;
    a_in = W'(a); b_in = W'(b); mode_in = 1'(m);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 2000) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: got no accept after %0d cycles expected accept", budget);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (scramble) begin
        a_in = W'($urandom_range(0, N - 1));
        b_in = W'($urandom_range(0, N - 1));
        mode_in = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk);
    push_pair(int'(a_in), int'(b_in), int'(mode_in));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      budget++;
      if (budget > 3000) begin
        checks++;
        failures++;
        $display("FAIL idle_timeout: got %0d beats pending expected 0", exp_q.size());
        exp_q.delete();
        str_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a_in = '0; b_in = '0; mode_in = 1'b0;
    #3;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_bs_valid", int'(bs_valid), 0);
    chk("rst_a_bs", int'(a_bs), 0);
    chk("rst_b_bs", int'(b_bs), 0);
    chk("rst_bs_last", int'(bs_last), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Extremes, correlated nesting, and bit-reversed decorrelation.
    send(0, 63, 0, 0);
    wait_idle();
    send(16, 40, 0, 0);
    wait_idle();
    send(32, 32, 1, 0);
    wait_idle();

    // Back-to-back under random backpressure.
    stall_en = 1;
    send(5, 9, 0, 0);
    send(10, 20, 0, 0);
    wait_idle();
    stall_en = 0;
    @(posedge clk);
    #1;

    // Reset in the middle of a stream at cnt = 30.
    send(50, 50, 0, 0);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_bs_valid", int'(bs_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_a_bs", int'(a_bs), 0);
    exp_q.delete();
    str_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(7, 3, 0, 0);
    wait_idle();

    // Pending pair with changing data presented mid-stream.
    send(20, 30, 1, 0);
    repeat (10) @(posedge clk);
    #1;
    send(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)), 0, 1);
    wait_idle();

    // Random pairs, mixing back-to-back and idle gaps, with backpressure.
    stall_en = 1;
    for (int i = 0; i < 8; i++) begin
      send(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
           int'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    stall_en = 0;
    wait_idle();
    chk("drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsc_pair_sng.md
# dsc_pair_sng

Deterministic bitstream generator for a sorted pair of `SNG_WIDTH`-bit binary values. It sits directly downstream of the 2-input compare-and-swap stage in the DSC datapath. It accepts one (a, b) pair per load through a valid/ready handshake, then emits two 2^`SNG_WIDTH`-bit unary bitstreams whose ones-counts equal the loaded values. Stream B can be correlated with stream A, or decorrelated from it by a bit-reversed counter.

## Interface

- `SNG_WIDTH`, 6, width of binary operands; stream length is N = 2^`SNG_WIDTH`.
- `clk`  input  1  single clock, all state on rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  pair on `a_in`/`b_in`/`mode_in` is valid.
- `in_ready`  output  1  block can accept a pair this cycle.
- `a_in`  input  `SNG_WIDTH`  operand A (CAS `a_new`).
- `b_in`  input  `SNG_WIDTH`  operand B (CAS `b_new`).
- `mode_in`  input  1  0 = B compared against the linear counter (correlated); 1 = B compared against the bit-reversed counter (uncorrelated).
- `bs_valid`  output  1  `a_bs`/`b_bs`/`bs_last` are valid.
- `out_ready`  input  1  consumer accepts the current bit pair.
- `a_bs`  output  1  stream A bit.
- `b_bs`  output  1  stream B bit.
- `bs_last`  output  1  current beat is bit N-1 of the stream.

## Operation

- Registers: `state` ∈ {IDLE, STREAM}, `a_reg`, `b_reg`, `mode_reg`, and `cnt` (`SNG_WIDTH` bits, unsigned).
- Input transfer: `in_valid && in_ready`. Output beat: `bs_valid && out_ready`.
- IDLE: `in_ready`=1, `bs_valid`=0. On an input transfer, latch `a_in`, `b_in`, `mode_in`, set `cnt`=0, and go to STREAM.
- STREAM: `bs_valid`=1, with
  - `a_bs` = (`a_reg` > `cnt`)
  - `b_bs` = (`b_reg` > `cmp_b`), where `cmp_b` = `mode_reg` ? bitrev(`cnt`) : `cnt`
  - `bs_last` = (`cnt` == N-1)
- All comparisons are unsigned and `SNG_WIDTH` bits wide. Ones-count of each stream over N beats equals the operand value exactly, range 0..N-1. A value of N-1 gives a trailing 0.
- On a beat with `cnt` < N-1: `cnt` increments.
- On a beat with `cnt` == N-1: the stream is complete.
  - If `in_valid`=1 in the same cycle (`in_ready`=1 there), reload the registers, set `cnt`=0, and stay in STREAM. This is back-to-back operation with no bubble.
  - Otherwise go to IDLE.
- `in_ready` = `rst_n` && (IDLE || (STREAM && `bs_last` && `out_ready`)). This is a combinational path from `out_ready` and is permitted.
- Stall: while `out_ready`=0 in STREAM, `cnt` and all outputs hold. `in_valid` is ignored except on the final accepted beat.
- Input data is not captured unless `in_ready`=1. `a_in`/`b_in` changing while not ready has no effect.
- Reset (rst_n low, any time including mid-stream): `state`=IDLE, `cnt`=0, `a_reg`=`b_reg`=0, `mode_reg`=0 immediately. The partial stream is discarded and no further beats are produced for it.

## Timing

- Reset values: `in_ready`=0 while `rst_n`=0, and 1 in the first cycle after release. `bs_valid`=0, `a_bs`=0, `b_bs`=0, `bs_last`=0.
- Latency: input transfer at edge k → first bit (`cnt`=0) valid in cycle k+1.
- A stream with no stalls occupies exactly N cycles of `bs_valid`.
- Throughput: one pair per N cycles back-to-back. With an IDLE gap, one pair per N+1 cycles.
- Output outputs are decoded from registered state only. There is no combinational path from `a_in`/`b_in` to `a_bs`/`b_bs`.

## Test plan

- Reset then load a=0, b=63, mode=0, `out_ready`=1. Required response: 64 beats; `a_bs` all 0; `b_bs`=1 for cnt 0..62 and 0 at cnt 63; `bs_last` only on beat 63; return to IDLE.
- Correlated: a=16, b=40, mode=0. Required response: ones(A)=16, ones(B)=40, ones(A&B)=16 (A ones at cnt 0..15 nested inside B).
- Uncorrelated: a=32, b=32, mode=1. Required response: A=1 for cnt<32; B=1 for even cnt; ones(A)=ones(B)=32; ones(A&B)=16.
- Back-to-back with backpressure: load (5,9), `in_valid` held with (10,20); `out_ready` toggles 1,0,0,1 randomly. Required response:
  - No beat is lost or repeated.
  - The second load is accepted exactly on the first pair's `bs_last` beat.
  - The second stream's cnt-0 beat appears the next cycle.
  - ones-counts are 5/9 then 10/20.
- Reset mid-stream: assert `rst_n`=0 at cnt=30 of (50,50). Required response:
  - `bs_valid` drops asynchronously.
  - After release, `in_ready`=1, and a new load (7,3) yields a clean 64-beat stream with ones-counts 7/3.
- Ignored input: drive `in_valid`=1 with changing data mid-stream (cnt 10..20) while `out_ready`=1. Required response: current stream is unaffected; the pending data is taken only on `bs_last`.
